// File: rtl/arb_req_queue.sv
// ---------------------------------------------------------------------------
// arb_req_queue
//
// Per-requester request queues that sit in front of a round-robin arbiter
// (arbiter_rr). Each requester owns an independent circular FIFO. The
// non-empty vector goes to the arbiter as its request vector. The arbiter's
// grant (ack_*) pops the head of the granted FIFO onto a registered dequeue
// port one cycle later.
//
// Parameters
//   REQUESTER_COUNT      number of requesters (power of 2, >= 2)
//   LOG_REQUESTER_COUNT  requester index width
//   DATA_WIDTH           payload bits per request
//   FIFO_DEPTH           entries per requester FIFO (power of 2, >= 2)
//
// Ports
//   CLK                  clock, all state updates on the rising edge
//   RST                  asynchronous active-high reset
//   enq_valid_by_req     per-requester enqueue request
//   enq_data_by_req      payloads, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   enq_ready_by_req     per-requester space available (registered state only)
//   req_vec              per-requester non-empty flag, to arbiter_rr req_vec
//   ack_valid            grant valid from arbiter_rr
//   ack_one_hot          grant one-hot from arbiter_rr
//   ack_index            granted requester index from arbiter_rr
//   deq_valid            granted payload valid (1-cycle after the grant)
//   deq_data             granted payload, held while deq_valid is 0
//   deq_index            requester that deq_data came from
//   ack_err              sticky grant-protocol error
//
// Configuration
//   ARB_REQ_QUEUE_ACK_CHECK_EN  when defined, ack_err flags grants to an
//                               empty FIFO or a one-hot that disagrees with
//                               ack_index. It stays set until reset. When
//                               undefined, ack_err is tied to 0.
// ---------------------------------------------------------------------------
module arb_req_queue #(
  parameter int REQUESTER_COUNT     = 4,
  parameter int LOG_REQUESTER_COUNT = $clog2(REQUESTER_COUNT),
  parameter int DATA_WIDTH          = 32,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                                  CLK,
  input  logic                                  RST,
  input  logic [REQUESTER_COUNT-1:0]            enq_valid_by_req,
  input  logic [REQUESTER_COUNT*DATA_WIDTH-1:0] enq_data_by_req,
  output logic [REQUESTER_COUNT-1:0]            enq_ready_by_req,
  output logic [REQUESTER_COUNT-1:0]            req_vec,
  input  logic                                  ack_valid,
  input  logic [REQUESTER_COUNT-1:0]            ack_one_hot,
  input  logic [LOG_REQUESTER_COUNT-1:0]        ack_index,
  output logic                                  deq_valid,
  output logic [DATA_WIDTH-1:0]                 deq_data,
  output logic [LOG_REQUESTER_COUNT-1:0]        deq_index,
  output logic                                  ack_err
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

  // Payload storage and per-FIFO bookkeeping.
  logic [DATA_WIDTH-1:0] mem   [REQUESTER_COUNT][FIFO_DEPTH];
  logic [PTR_W-1:0]      head  [REQUESTER_COUNT];
  logic [PTR_W-1:0]      tail  [REQUESTER_COUNT];
  logic [CNT_W-1:0]      count [REQUESTER_COUNT];

  logic [REQUESTER_COUNT-1:0] enq_fire;
  logic [REQUESTER_COUNT-1:0] deq_sel;
  logic                       deq_fire;

  // Ready and non-empty come from the counters alone. Inputs have no
  // combinational path to them, so the arbiter loop stays free of
  // combinational cycles. A new entry also shows on req_vec only after the
  // edge that wrote it.
  always_comb begin
    for (int i = 0; i < REQUESTER_COUNT; i++) begin
      enq_ready_by_req[i] = (count[i] < FULL_CNT);
      req_vec[i]          = (count[i] != '0);
    end
  end

  // A full FIFO refuses the enqueue even when it is being drained in the
  // same cycle, because ready does not look at the grant.
  assign enq_fire = enq_valid_by_req & enq_ready_by_req;

  // A grant to an empty FIFO is ignored.
  assign deq_fire = ack_valid & req_vec[ack_index];

  // NOTE: every signal written in always_comb gets a default value first.
  // Otherwise a path that skips the assignment infers a latch.
  always_comb begin
    deq_sel = '0;
    if (deq_fire) deq_sel[ack_index] = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only. Every
  // register then samples pre-edge values, whatever the statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < REQUESTER_COUNT; i++) begin
        head[i]  <= '0;
        tail[i]  <= '0;
        count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < REQUESTER_COUNT; i++) begin
        if (enq_fire[i]) tail[i] <= tail[i] + 1'b1;  // wraps: depth is 2^n
        if (deq_sel[i])  head[i] <= head[i] + 1'b1;
        case ({enq_fire[i], deq_sel[i]})
          2'b10:   count[i] <= count[i] + 1'b1;
          2'b01:   count[i] <= count[i] - 1'b1;
          default: ;  // idle, or push and pop together: count unchanged
        endcase
      end
    end
  end

  // NOTE: payload storage has no reset. Clearing the counters and pointers
  // already makes the old contents unreachable, and a resettable RAM would
  // not map onto memory macros.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < REQUESTER_COUNT; i++) begin
      if (enq_fire[i]) mem[i][tail[i]] <= enq_data_by_req[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Registered dequeue port. Data and index hold their last values when
  // there is no dequeue.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      deq_valid <= 1'b0;
      deq_data  <= '0;
      deq_index <= '0;
    end else begin
      deq_valid <= deq_fire;
      if (deq_fire) begin
        deq_data  <= mem[ack_index][head[ack_index]];
        deq_index <= ack_index;
      end
    end
  end

`ifdef ARB_REQ_QUEUE_ACK_CHECK_EN
  // One-hot that a well-formed grant for ack_index must carry.
  logic [REQUESTER_COUNT-1:0] exp_one_hot;

  always_comb begin
    exp_one_hot            = '0;
    exp_one_hot[ack_index] = 1'b1;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ack_err <= 1'b0;
    end else if (ack_valid && (!req_vec[ack_index] || (ack_one_hot != exp_one_hot))) begin
      ack_err <= 1'b1;
    end
  end
`else
  assign ack_err = 1'b0;

  // Without the checker the grant one-hot has no consumer. The sink below
  // keeps the port explicit and synthesizes to nothing.
  logic unused_ack_one_hot;
  assign unused_ack_one_hot = ^ack_one_hot;
`endif

endmodule

// File: tb/tb_arb_req_queue.sv
// ---------------------------------------------------------------------------
// tb_arb_req_queue
//
// Directed bench for arb_req_queue with default parameters (4 requesters,
// 32-bit payload, depth 4). It drives inputs 1 time unit after the rising
// edge and samples outputs at the same point after the next edge. The
// closing scenario uses a behavioural round-robin arbiter in the bench and
// a per-requester expected-payload queue.
// ---------------------------------------------------------------------------
module tb_arb_req_queue;

  localparam int R  = 4;
  localparam int LR = 2;
  localparam int DW = 32;

  logic            CLK;
  logic            RST;
  logic [R-1:0]    enq_valid_by_req;
  logic [R*DW-1:0] enq_data_by_req;
  logic [R-1:0]    enq_ready_by_req;
  logic [R-1:0]    req_vec;
  logic            ack_valid;
  logic [R-1:0]    ack_one_hot;
  logic [LR-1:0]   ack_index;
  logic            deq_valid;
  logic [DW-1:0]   deq_data;
  logic [LR-1:0]   deq_index;
  logic            ack_err;

  int n_cmp = 0;
  int n_err = 0;

`ifdef ARB_REQ_QUEUE_ACK_CHECK_EN
  localparam logic EXP_EMPTY_ACK_ERR = 1'b1;
`else
  localparam logic EXP_EMPTY_ACK_ERR = 1'b0;
`endif

  arb_req_queue #(
    .REQUESTER_COUNT (R),
    .DATA_WIDTH      (DW),
    .FIFO_DEPTH      (4)
  ) dut (
    .CLK              (CLK),
    .RST              (RST),
    .enq_valid_by_req (enq_valid_by_req),
    .enq_data_by_req  (enq_data_by_req),
    .enq_ready_by_req (enq_ready_by_req),
    .req_vec          (req_vec),
    .ack_valid        (ack_valid),
    .ack_one_hot      (ack_one_hot),
    .ack_index        (ack_index),
    .deq_valid        (deq_valid),
    .deq_data         (deq_data),
    .deq_index        (deq_index),
    .ack_err          (ack_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive_enq(input int idx, input logic [DW-1:0] data);
    enq_valid_by_req[idx]           = 1'b1;
    enq_data_by_req[idx*DW +: DW]   = data;
  endtask

  task automatic clear_enq();
    enq_valid_by_req = '0;
  endtask

  task automatic set_ack(input logic v, input int idx);
    ack_valid   = v;
    ack_index   = LR'(idx);
    ack_one_hot = v ? (R'(1) << idx) : '0;
  endtask

  // -------------------------------------------------------------------------
  task automatic test_reset();
    RST = 1'b1;
    enq_valid_by_req = '0;
    enq_data_by_req  = '0;
    set_ack(1'b0, 0);
    #2;  // before the first clock edge: reset must already be in effect
    n_cmp++; if (enq_ready_by_req !== 4'b1111) begin n_err++; $display("FAIL reset_ready got %b want 1111", enq_ready_by_req); end
    n_cmp++; if (req_vec !== 4'b0000) begin n_err++; $display("FAIL reset_req_vec got %b want 0000", req_vec); end
    n_cmp++; if (deq_valid !== 1'b0) begin n_err++; $display("FAIL reset_deq_valid got %b want 0", deq_valid); end
    n_cmp++; if (deq_data !== '0 || deq_index !== '0) begin n_err++; $display("FAIL reset_deq_port got %h/%0d want 0/0", deq_data, deq_index); end
    n_cmp++; if (ack_err !== 1'b0) begin n_err++; $display("FAIL reset_ack_err got %b want 0", ack_err); end
    tick();
    tick();
    RST = 1'b0;
    tick();
  endtask

  // Two pushes to requester 2, then two grants return them in order.
  task automatic test_basic();
    drive_enq(2, 32'hA1);
    #1;
    n_cmp++; if (req_vec !== 4'b0000) begin n_err++; $display("FAIL no_bypass got %b want 0000", req_vec); end
    tick();
    n_cmp++; if (req_vec !== 4'b0100) begin n_err++; $display("FAIL first_push_req_vec got %b want 0100", req_vec); end
    drive_enq(2, 32'hA2);
    tick();
    clear_enq();
    set_ack(1'b1, 2);
    tick();
    n_cmp++; if (deq_valid !== 1'b1 || deq_data !== 32'hA1 || deq_index !== 2'd2) begin n_err++; $display("FAIL basic_deq0 got v=%b d=%h i=%0d want v=1 d=a1 i=2", deq_valid, deq_data, deq_index); end
    tick();
    n_cmp++; if (deq_valid !== 1'b1 || deq_data !== 32'hA2 || deq_index !== 2'd2) begin n_err++; $display("FAIL basic_deq1 got v=%b d=%h i=%0d want v=1 d=a2 i=2", deq_valid, deq_data, deq_index); end
    set_ack(1'b0, 0);
    tick();
    n_cmp++; if (deq_valid !== 1'b0 || deq_data !== 32'hA2 || req_vec !== 4'b0000) begin n_err++; $display("FAIL basic_idle got v=%b d=%h rv=%b want v=0 d=a2 rv=0000", deq_valid, deq_data, req_vec); end
  endtask

  // Fill requester 1, then push and grant together: the push must be refused.
  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      drive_enq(1, 32'hB0 + k);
      tick();
    end
    clear_enq();
    n_cmp++; if (enq_ready_by_req !== 4'b1101 || req_vec !== 4'b0010) begin n_err++; $display("FAIL full_flags got rdy=%b rv=%b want rdy=1101 rv=0010", enq_ready_by_req, req_vec); end
    drive_enq(1, 32'hBF);
    set_ack(1'b1, 1);
    tick();
    clear_enq();
    n_cmp++; if (deq_data !== 32'hB0 || enq_ready_by_req[1] !== 1'b1) begin n_err++; $display("FAIL full_push_pop got d=%h rdy1=%b want d=b0 rdy1=1", deq_data, enq_ready_by_req[1]); end
    for (int k = 1; k < 4; k++) begin
      tick();
      n_cmp++; if (deq_valid !== 1'b1 || deq_data !== 32'hB0 + k) begin n_err++; $display("FAIL full_drain%0d got v=%b d=%h want v=1 d=%h", k, deq_valid, deq_data, 32'hB0 + k); end
    end
    set_ack(1'b0, 0);
    tick();
    n_cmp++; if (req_vec !== 4'b0000) begin n_err++; $display("FAIL full_rejected got rv=%b want 0000", req_vec); end
  endtask

  // Requester 3 holds 2 entries while push+pop continue past the wrap point.
  task automatic test_wrap();
    drive_enq(3, 32'hC0);
    tick();
    drive_enq(3, 32'hC1);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive_enq(3, 32'hC2 + k);
      set_ack(1'b1, 3);
      tick();
      n_cmp++; if (deq_valid !== 1'b1 || deq_data !== 32'hC0 + k || req_vec !== 4'b1000 || enq_ready_by_req !== 4'b1111) begin
        n_err++; $display("FAIL wrap_step%0d got v=%b d=%h rv=%b rdy=%b want v=1 d=%h rv=1000 rdy=1111", k, deq_valid, deq_data, req_vec, enq_ready_by_req, 32'hC0 + k);
      end
    end
    clear_enq();
    tick();
    n_cmp++; if (deq_data !== 32'hC4 || deq_index !== 2'd3) begin n_err++; $display("FAIL wrap_tail0 got d=%h i=%0d want d=c4 i=3", deq_data, deq_index); end
    tick();
    n_cmp++; if (deq_data !== 32'hC5 || req_vec !== 4'b0000) begin n_err++; $display("FAIL wrap_tail1 got d=%h rv=%b want d=c5 rv=0000", deq_data, req_vec); end
    set_ack(1'b0, 0);
    tick();
  endtask

  // A grant to empty FIFO 0 changes nothing, except the optional error flag.
  task automatic test_empty_ack();
    set_ack(1'b1, 0);
    tick();
    n_cmp++; if (deq_valid !== 1'b0 || deq_data !== 32'hC5 || req_vec !== 4'b0000) begin n_err++; $display("FAIL empty_ack got v=%b d=%h rv=%b want v=0 d=c5 rv=0000", deq_valid, deq_data, req_vec); end
    n_cmp++; if (ack_err !== EXP_EMPTY_ACK_ERR) begin n_err++; $display("FAIL empty_ack_err got %b want %b", ack_err, EXP_EMPTY_ACK_ERR); end
    set_ack(1'b0, 0);
    tick();
    tick();
    n_cmp++; if (ack_err !== EXP_EMPTY_ACK_ERR) begin n_err++; $display("FAIL ack_err_sticky got %b want %b", ack_err, EXP_EMPTY_ACK_ERR); end
    drive_enq(0, 32'hD0);
    tick();
    clear_enq();
    set_ack(1'b1, 0);
    tick();
    n_cmp++; if (deq_valid !== 1'b1 || deq_data !== 32'hD0 || deq_index !== 2'd0) begin n_err++; $display("FAIL empty_ack_after got v=%b d=%h i=%0d want v=1 d=d0 i=0", deq_valid, deq_data, deq_index); end
    set_ack(1'b0, 0);
    tick();
  endtask

  // Asynchronous reset with all FIFOs partly full and a dequeue in flight.
  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < R; i++) drive_enq(i, 32'hE000 + 32'(i * 16 + k));
      tick();
    end
    clear_enq();
    n_cmp++; if (req_vec !== 4'b1111) begin n_err++; $display("FAIL mid_prefill got rv=%b want 1111", req_vec); end
    set_ack(1'b1, 1);
    tick();
    set_ack(1'b0, 0);
    #2;
    RST = 1'b1;
    #1;
    n_cmp++; if (req_vec !== 4'b0000 || deq_valid !== 1'b0 || enq_ready_by_req !== 4'b1111) begin n_err++; $display("FAIL mid_reset_async got rv=%b v=%b rdy=%b want 0000/0/1111", req_vec, deq_valid, enq_ready_by_req); end
    n_cmp++; if (deq_data !== '0 || deq_index !== '0 || ack_err !== 1'b0) begin n_err++; $display("FAIL mid_reset_port got d=%h i=%0d err=%b want 0/0/0", deq_data, deq_index, ack_err); end
    tick();
    RST = 1'b0;
    tick();
    tick();
    n_cmp++; if (req_vec !== 4'b0000 || deq_valid !== 1'b0) begin n_err++; $display("FAIL mid_post_reset got rv=%b v=%b want 0000/0", req_vec, deq_valid); end
    drive_enq(2, 32'hF0);
    tick();
    clear_enq();
    set_ack(1'b1, 2);
    tick();
    n_cmp++; if (deq_data !== 32'hF0 || deq_index !== 2'd2 || req_vec !== 4'b0000) begin n_err++; $display("FAIL mid_no_stale got d=%h i=%0d rv=%b want f0/2/0000", deq_data, deq_index, req_vec); end
    set_ack(1'b0, 0);
    tick();
  endtask

  // Closed loop against a behavioural round-robin arbiter.
  task automatic test_closed_loop();
    localparam int PER_REQ = 8;
    localparam int TOTAL   = R * PER_REQ;
    logic [DW-1:0] exp_q [R][$];
    int sent [R];
    int rr_last  = R - 1;
    int received = 0;
    int cycles   = 0;
    bit found;
    int idx;
    logic [DW-1:0] exp_d;

    for (int i = 0; i < R; i++) sent[i] = 0;
    while (received < TOTAL && cycles < 2000) begin
      if (deq_valid === 1'b1) begin
        received++;
        n_cmp++;
        if (exp_q[deq_index].size() == 0) begin
          n_err++; $display("FAIL loop_unexpected got d=%h i=%0d want no dequeue", deq_data, deq_index);
        end else begin
          exp_d = exp_q[deq_index].pop_front();
          if (deq_data !== exp_d) begin n_err++; $display("FAIL loop_order i=%0d got %h want %h", deq_index, deq_data, exp_d); end
        end
      end
      found = 1'b0;
      idx   = 0;
      for (int k = 1; k <= R; k++) begin
        if (!found && req_vec[(rr_last + k) % R]) begin
          found = 1'b1;
          idx   = (rr_last + k) % R;
        end
      end
      if (found) begin
        set_ack(1'b1, idx);
        rr_last = idx;
      end else begin
        set_ack(1'b0, 0);
      end
      for (int i = 0; i < R; i++) begin
        enq_valid_by_req[i] = 1'b0;
        if (sent[i] < PER_REQ && $urandom_range(0, 2) != 0) begin
          drive_enq(i, {8'(i), 8'(sent[i]), 16'($urandom)});
          if (enq_ready_by_req[i]) begin
            exp_q[i].push_back(enq_data_by_req[i*DW +: DW]);
            sent[i]++;
          end
        end
      end
      tick();
      cycles++;
    end
    clear_enq();
    set_ack(1'b0, 0);
    n_cmp++; if (received !== TOTAL) begin n_err++; $display("FAIL loop_complete got %0d dequeued want %0d (cycles %0d)", received, TOTAL, cycles); end
    tick();
    n_cmp++; if (ack_err !== 1'b0 || req_vec !== 4'b0000) begin n_err++; $display("FAIL loop_end got err=%b rv=%b want 0/0000", ack_err, req_vec); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_empty_ack();
    test_reset_mid();
    test_closed_loop();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/arb_req_queue.md
ARB_REQ_QUEUE -- requirements
Module: arb_req_queue

Interface
REQ-001 The block SHALL have parameter REQUESTER_COUNT, default 4, number of requesters (power of 2, >=2).
REQ-002 The block SHALL have parameter LOG_REQUESTER_COUNT, default $clog2(REQUESTER_COUNT), index width.
REQ-003 The block SHALL have parameter DATA_WIDTH, default 32, payload bits per request.
REQ-004 The block SHALL have parameter FIFO_DEPTH, default 4, entries per requester (power of 2, >=2).
REQ-005 The block SHALL have the following ports:
- CLK  in  1  clock; one clock, all state on rising edge.
- RST  in  1  reset; asynchronous, active-high.
- enq_valid_by_req  in  REQUESTER_COUNT  per-requester enqueue request.
- enq_data_by_req  in  REQUESTER_COUNT*DATA_WIDTH  payloads; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- enq_ready_by_req  out  REQUESTER_COUNT  per-requester space available.
- req_vec  out  REQUESTER_COUNT  non-empty vector; drives arbiter_rr req_vec.
- ack_valid  in  1  grant valid from arbiter_rr.
- ack_one_hot  in  REQUESTER_COUNT  grant one-hot from arbiter_rr.
- ack_index  in  LOG_REQUESTER_COUNT  granted requester index from arbiter_rr.
- deq_valid  out  1  granted payload valid.
- deq_data  out  DATA_WIDTH  granted payload.
- deq_index  out  LOG_REQUESTER_COUNT  requester of deq_data.
- ack_err  out  1  sticky grant-protocol error.

Function
REQ-006 The block SHALL hold one independent circular FIFO of FIFO_DEPTH entries per requester, each with head pointer, tail pointer and count of LOG2(FIFO_DEPTH)+1 bits.
REQ-007 enq_ready_by_req[i] SHALL be 1 exactly when count[i] < FIFO_DEPTH, derived from registered state only (no combinational path from any input).
REQ-008 An enqueue to FIFO i SHALL occur when enq_valid_by_req[i] and enq_ready_by_req[i] are both 1: the payload is written at tail[i], and tail[i] increments modulo FIFO_DEPTH.
REQ-009 req_vec[i] SHALL be 1 exactly when count[i] != 0, derived from registered state only.
REQ-010 A dequeue from FIFO ack_index SHALL occur when ack_valid=1 and count[ack_index] != 0: head[ack_index] increments modulo FIFO_DEPTH.
REQ-011 On a dequeue, the cycle after the edge SHALL show deq_valid=1, deq_data=the head entry, deq_index=ack_index (1-cycle latency); otherwise deq_valid=0, and deq_data/deq_index hold their previous values.
REQ-012 A simultaneous enqueue and dequeue on the same FIFO SHALL leave its count unchanged and advance both pointers; a full FIFO SHALL not accept enqueue in that cycle, even if it is dequeued.
REQ-013 An enqueued entry SHALL become visible on req_vec no earlier than the cycle after the enqueue (no bypass).
REQ-014 ack_valid=1 with count[ack_index]=0 SHALL cause no dequeue, no pointer change, and deq_valid=0 next cycle.
REQ-015 Per-requester FIFO order SHALL be preserved; independent requesters SHALL never affect each other's counts or pointers.

Reset
REQ-016 While RST=1, the block SHALL asynchronously clear all pointers and counts and force outputs as follows: enq_ready_by_req all ones, req_vec=0, deq_valid=0, deq_data=0, deq_index=0, ack_err=0.
REQ-017 When RST asserts mid-operation, the block SHALL discard all queued entries; FIFO data storage need not be cleared.

Configuration
REQ-018 With macro ARB_REQ_QUEUE_ACK_CHECK_EN defined, ack_err SHALL set on the edge after any ack_valid=1 where count[ack_index]=0 or ack_one_hot != (1 << ack_index), and stay 1 until reset.
REQ-019 Without ARB_REQ_QUEUE_ACK_CHECK_EN, ack_err SHALL be constant 0 and the block SHALL implement no check logic.

Verification
REQ-020 Test: reset, push 0xA1, 0xA2 to requester 2 -> req_vec=4'b0100 the cycle after the first push; acks at index 2 on two cycles -> deq_data 0xA1 then 0xA2, deq_index=2.
REQ-021 Test: fill requester 1 with 4 entries -> enq_ready_by_req[1]=0; enqueue and ack index 1 in the same cycle -> enqueue rejected, count becomes 3, ready=1 the next cycle.
REQ-022 Test: with count[3]=2, enqueue and ack index 3 in the same cycle -> count stays 2, deq_data = oldest entry, and the FIFO order is correct after the pointer wraps past entry 3.
REQ-023 Test: ack_valid=1, ack_index=0, FIFO 0 empty -> deq_valid=0 and no state change; with ARB_REQ_QUEUE_ACK_CHECK_EN, ack_err=1 and stays 1.
REQ-024 Test: assert RST while all FIFOs are partially full -> immediately req_vec=0, deq_valid=0, enq_ready_by_req=4'b1111, and no stale entries appear after reset is released.
REQ-025 Test: closed loop with arbiter_rr, all 4 requesters pushing random payloads -> every payload is dequeued once, per-requester order is preserved, and ack_err=0.
